// File: rtl/led_fade_sequencer_if.sv
// rtl/led_fade_sequencer_if.sv - control/status bundle between board controls, sequencer and PWM generator
interface led_fade_sequencer_if #(
   parameter int DUTY_W = 4
);
   logic              enable;
   logic              oneshot;
   logic [DUTY_W-1:0] dutyc;
   logic [2:0]        phase;
   logic              busy;
   logic              cycle_done;

   modport master (
      output enable,
      output oneshot,
      input  dutyc,
      input  phase,
      input  busy,
      input  cycle_done
   );

   modport slave (
      input  enable,
      input  oneshot,
      output dutyc,
      output phase,
      output busy,
      output cycle_done
   );
endinterface

// File: rtl/led_fade_sequencer.sv
// rtl/led_fade_sequencer.sv - breathing brightness sequencer feeding the LED PWM duty code (optional LED_FADE_GAMMA_EN)
module led_fade_sequencer #(
   parameter int DUTY_W     = 4,
   parameter int STEP_DIV   = 1562500,
   parameter int HOLD_STEPS = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   led_fade_sequencer_if.slave  bus
);
   localparam int PRE_W  = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
   localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS + 1) : 1;

   localparam logic [DUTY_W-1:0] LEVEL_MAX = '1;
   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(STEP_DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RAMP_UP = 3'd1,
      S_HOLD_HI = 3'd2,
      S_RAMP_DN = 3'd3,
      S_HOLD_LO = 3'd4
   } state_t;

`ifdef LED_FADE_GAMMA_EN
   // Perceptual curve: low codes stay dim longer so the fade looks linear to the eye.
   localparam logic [3:0] GAMMA [16] = '{
      4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3,
      4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd11, 4'd13, 4'd15
   };

   if (DUTY_W != 4) begin : g_gamma_width
      $error("LED_FADE_GAMMA_EN requires DUTY_W == 4");
   end

   function automatic logic [DUTY_W-1:0] map_level(input logic [DUTY_W-1:0] lv);
      return DUTY_W'(GAMMA[lv]);
   endfunction
`else
   function automatic logic [DUTY_W-1:0] map_level(input logic [DUTY_W-1:0] lv);
      return lv;
   endfunction
`endif

   state_t            state_q;
   logic [DUTY_W-1:0] level_q;
   logic [DUTY_W-1:0] dutyc_q;
   logic [HOLD_W-1:0] hold_cnt;
   logic [PRE_W-1:0]  presc;
   logic              busy_q;
   logic              cycle_done_q;
   logic              tick;

   assign tick           = busy_q && (presc == PRE_LAST);
   assign bus.dutyc      = dutyc_q;
   assign bus.phase      = state_q;
   assign bus.busy       = busy_q;
   assign bus.cycle_done = cycle_done_q;

   // Step prescaler: free-runs only while a sequence is active, parked at zero otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
      end else if (!bus.enable || !busy_q || tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PRE_W'(1);
      end
   end

   // Sequencer FSM; dutyc is loaded with the mapped level on the same edge the level moves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         level_q      <= '0;
         dutyc_q      <= '0;
         hold_cnt     <= '0;
         busy_q       <= 1'b0;
         cycle_done_q <= 1'b0;
      end else if (!bus.enable) begin
         // Abort wins over any tick in the same cycle and never reports a completed cycle.
         state_q      <= S_IDLE;
         level_q      <= '0;
         dutyc_q      <= '0;
         hold_cnt     <= '0;
         busy_q       <= 1'b0;
         cycle_done_q <= 1'b0;
      end else begin
         cycle_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               level_q  <= '0;
               dutyc_q  <= map_level('0);
               hold_cnt <= '0;
               state_q  <= S_RAMP_UP;
               busy_q   <= 1'b1;
            end
            S_RAMP_UP: begin
               if (tick) begin
                  if (level_q != LEVEL_MAX) begin
                     level_q <= level_q + DUTY_W'(1);
                     dutyc_q <= map_level(level_q + DUTY_W'(1));
                  end else begin
                     state_q  <= S_HOLD_HI;
                     hold_cnt <= '0;
                  end
               end
            end
            S_HOLD_HI: begin
               if (tick) begin
                  if (hold_cnt == HOLD_LAST) begin
                     state_q  <= S_RAMP_DN;
                     hold_cnt <= '0;
                  end else begin
                     hold_cnt <= hold_cnt + HOLD_W'(1);
                  end
               end
            end
            S_RAMP_DN: begin
               if (tick) begin
                  if (level_q != '0) begin
                     level_q <= level_q - DUTY_W'(1);
                     dutyc_q <= map_level(level_q - DUTY_W'(1));
                  end else begin
                     state_q  <= S_HOLD_LO;
                     hold_cnt <= '0;
                  end
               end
            end
            S_HOLD_LO: begin
               if (tick) begin
                  if (hold_cnt == HOLD_LAST) begin
                     // End of a full cycle: oneshot is only looked at here.
                     cycle_done_q <= 1'b1;
                     hold_cnt     <= '0;
                     if (bus.oneshot) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                     end else begin
                        state_q <= S_RAMP_UP;
                     end
                  end else begin
                     hold_cnt <= hold_cnt + HOLD_W'(1);
                  end
               end
            end
            default: begin
               state_q  <= S_IDLE;
               level_q  <= '0;
               dutyc_q  <= '0;
               hold_cnt <= '0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_led_fade_sequencer.sv
// tb/tb_led_fade_sequencer.sv - scoreboard bench for led_fade_sequencer
module tb_led_fade_sequencer;
   localparam int SD        = 4;
   localparam int HS        = 2;
   localparam int MAXL      = 15;
   localparam int CYC_TICKS = 2 * (MAXL + 1) + 2 * HS;
   localparam int CYC_CLKS  = CYC_TICKS * SD;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   led_fade_sequencer_if #(.DUTY_W(4)) bus ();

   led_fade_sequencer #(
      .DUTY_W    (4),
      .STEP_DIV  (SD),
      .HOLD_STEPS(HS)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [8:0] exp_q[$];

   bit m_run = 1'b0;
   int m_k = 0;
   int m_ph = 0;
   int m_lv = 0;
   int m_done_cnt = 0;
   int dut_done_cnt = 0;
   int hi_cnt = 0;
   int lo_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int exp_map(input int lv);
`ifdef LED_FADE_GAMMA_EN
      int g[16];
      g = '{0, 0, 0, 1, 1, 2, 2, 3, 4, 5, 6, 8, 9, 11, 13, 15};
      return g[lv];
`else
      return lv;
`endif
   endfunction

   // Predict outputs after the coming edge from clocks elapsed since the run started.
   task automatic model_step();
      int n, c, ph, lv;
      bit done;
      done = 1'b0;
      ph = 0;
      lv = 0;
      if (!bus.enable) begin
         m_run = 1'b0;
      end else if (!m_run) begin
         m_run = 1'b1;
         m_k = 0;
      end else begin
         m_k++;
         if (m_k % CYC_CLKS == 0) begin
            done = 1'b1;
            m_done_cnt++;
            if (bus.oneshot) m_run = 1'b0;
         end
      end
      if (m_run) begin
         n = m_k / SD;
         c = n % CYC_TICKS;
         if (c <= MAXL) begin
            ph = 1; lv = c;
         end else if (c < MAXL + 1 + HS) begin
            ph = 2; lv = MAXL;
         end else if (c < 2 * (MAXL + 1) + HS) begin
            ph = 3; lv = MAXL - (c - (MAXL + 1 + HS));
         end else begin
            ph = 4; lv = 0;
         end
      end
      m_ph = ph;
      m_lv = lv;
      exp_q.push_back({3'(ph), m_run, done, 4'(exp_map(lv))});
   endtask

   task automatic step(input bit en, input bit os);
      @(negedge clk);
      bus.enable = en;
      bus.oneshot = os;
      model_step();
   endtask

   task automatic run_to_done(input bit os, output int n);
      n = 0;
      for (int i = 0; i < CYC_CLKS + 20; i++) begin
         step(1'b1, os);
         n++;
         @(posedge clk);
         #1;
         if (bus.phase == 3'd2 && bus.dutyc == 4'(exp_map(MAXL))) hi_cnt++;
         if (bus.phase == 3'd4 && bus.dutyc == 4'(exp_map(0))) lo_cnt++;
         if (bus.cycle_done === 1'b1) break;
      end
   endtask

   // Compare every cycle's outputs against the scoreboard entry queued for that edge.
   always @(posedge clk) begin
      #1;
      if (bus.cycle_done === 1'b1) dut_done_cnt++;
      if (exp_q.size() > 0)
         check("out{phase,busy,done,dutyc}",
               {bus.phase, bus.busy, bus.cycle_done, bus.dutyc}, exp_q.pop_front());
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.enable = 1'b0;
      bus.oneshot = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_dutyc", bus.dutyc, 0);
      check("rst_phase", bus.phase, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.cycle_done, 0);
      rst_n = 1'b1;
      repeat (3) step(1'b0, 1'b0);

      // Enable from idle, first full cycle timing and hold lengths.
      step(1'b1, 1'b0);
      hi_cnt = 0;
      lo_cnt = 0;
      run_to_done(1'b0, n);
      check("first_done_clks", n, CYC_CLKS);
      check("hold_hi_clks", hi_cnt, HS * SD);
      check("hold_lo_clks", lo_cnt, HS * SD);

      // Free run: five consecutive cycles at a constant period.
      for (int i = 0; i < 5; i++) begin
         run_to_done(1'b0, n);
         check($sformatf("free_run_period_%0d", i), n, CYC_CLKS);
      end

      // Oneshot: stop in idle after the cycle in progress.
      run_to_done(1'b1, n);
      check("oneshot_period", n, CYC_CLKS);
      check("oneshot_phase", bus.phase, 0);
      check("oneshot_busy", bus.busy, 0);
      check("oneshot_dutyc", bus.dutyc, 0);
      repeat (3) step(1'b0, 1'b0);

      // Abort mid ramp-down at level 9, then restart from zero.
      step(1'b1, 1'b0);
      for (int i = 0; i < 2 * CYC_CLKS && !(m_ph == 3 && m_lv == 9); i++) step(1'b1, 1'b0);
      @(posedge clk);
      #1;
      check("abort_pre_phase", bus.phase, 3);
      check("abort_pre_dutyc", bus.dutyc, exp_map(9));
      step(1'b0, 1'b0);
      @(posedge clk);
      #1;
      check("abort_phase", bus.phase, 0);
      check("abort_dutyc", bus.dutyc, 0);
      check("abort_no_done", bus.cycle_done, 0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      repeat (SD * 6 + 1) step(1'b1, 1'b0);

      // Asynchronous reset in the middle of the ramp-up.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      bus.enable = 1'b0;
      #1;
      check("async_rst_dutyc", bus.dutyc, 0);
      check("async_rst_phase", bus.phase, 0);
      check("async_rst_busy", bus.busy, 0);
      m_run = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      repeat (SD * 3) step(1'b1, 1'b0);
      step(1'b0, 1'b0);

      @(posedge clk);
      #2;
      check("queue_drained", exp_q.size(), 0);
      check("done_count", dut_done_cnt, m_done_cnt);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
